serial_adder_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single `full_adder` instance across WIDTH clock cycles to add two WIDTH-bit operands, LSB first. It holds the running carry in a flip-flop and presents a start/busy/done handshake to the surrounding datapath. It is the area-minimal alternative to the ripple and carry-select adders: one full adder is time-shared instead of WIDTH of them.

---
 rtl/serial_adder_ctrl.sv | 136 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller time-sharing one full adder, LSB first
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opa_sh;
  logic [WIDTH-1:0] r_opb_sh;
  logic [WIDTH-1:0] r_acc_sh;
  logic             r_carry_q;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_opb_load;
  logic             w_cin_load;

  full_adder u_fa (
    .i_a    (r_opa_sh[0]),
    .i_b    (r_opb_sh[0]),
    .i_cin  (r_carry_q),
    .o_sum  (w_fa_sum),
    .o_cout (w_fa_cout)
  );

  // Subtraction is A + ~B + 1, so only the B and carry load values differ.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_opb_load = sub ? ~B : B;
  assign w_cin_load = sub ? 1'b1 : Cin;
`else
  assign w_opb_load = B;
  assign w_cin_load = Cin;
`endif

  generate
    if (WIDTH == 1) begin : g_acc_w1
      assign w_acc_nxt = w_fa_sum;
    end else begin : g_acc_wn
      assign w_acc_nxt = {w_fa_sum, r_acc_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == LAST);
  assign w_load = start && ((r_state == IDLE) || (r_state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sum/Cout are written only on the completion edge so partial results never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa_sh  <= '0;
      r_opb_sh  <= '0;
      r_acc_sh  <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
      Sum       <= '0;
      Cout      <= 1'b0;
    end else if (w_load) begin
      r_opa_sh  <= A;
      r_opb_sh  <= w_opb_load;
      r_acc_sh  <= '0;
      r_carry_q <= w_cin_load;
      r_cnt     <= '0;
    end else if (r_state == RUN) begin
      r_acc_sh  <= w_acc_nxt;
      r_opa_sh  <= r_opa_sh >> 1;
      r_opb_sh  <= r_opb_sh >> 1;
      r_carry_q <= w_fa_cout;
      r_cnt     <= r_cnt + 1'b1;
      if (w_last) begin
        Sum  <= w_acc_nxt;
        Cout <= w_fa_cout;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH=8
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t         sb_q[$];
  vec_t         vecs[8];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] held_sum = '0;
  logic         held_cout = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic vs, input logic [W-1:0] es, input logic ec);
    exp_t e;
    a = va;
    b = vb;
    cin = vc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = vs;
`else
    if (vs) $display("sub requested without subtract build");
`endif
    start = 1'b1;
    e.sum = es;
    e.cout = ec;
    sb_q.push_back(e);
  endtask

  // Waits for done after E0, checking busy and held outputs on every RUN cycle.
  // inject_at >= 0 raises start (with junk operands) after that many edges, for one edge.
  task automatic wait_done(input string tag, input int inject_at);
    int   lat = 0;
    bit   seen = 0;
    exp_t e;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        seen = 1;
        break;
      end
      check({tag, "_busy_run"}, 64'(busy), 64'(1));
      check({tag, "_sum_hold"}, 64'(sum), 64'(held_sum));
      check({tag, "_cout_hold"}, 64'(cout), 64'(held_cout));
      if (lat == inject_at) begin
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
      end else if (lat == inject_at + 1) begin
        start = 1'b0;
      end
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 64'(0), 64'(1));
    end else begin
      check({tag, "_latency"}, 64'(lat), 64'(W));
      check({tag, "_busy_done"}, 64'(busy), 64'(0));
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 64'(0), 64'(1));
      end else begin
        e = sb_q.pop_front();
        check({tag, "_sum"}, 64'(sum), 64'(e.sum));
        check({tag, "_cout"}, 64'(cout), 64'(e.cout));
        held_sum = e.sum;
        held_cout = e.cout;
      end
    end
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vc, input logic vs, input logic [W-1:0] es,
                         input logic ec, input int inject_at);
    issue(va, vb, vc, vs, es, ec);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_e0"}, 64'(busy), 64'(1));
    check({tag, "_done_e0"}, 64'(done), 64'(0));
    wait_done(tag, inject_at);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, 64'(done), 64'(0));
    check({tag, "_sum_after"}, 64'(sum), 64'(held_sum));
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 8; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
              vecs[i].sum, vecs[i].cout, -1);
    end

    // start pulsed during RUN (sampled at E3) must be ignored
    run_one("ignore_start", 8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 2);
    @(posedge clk);
    #1;
    check("ignore_start_idle", 64'(busy), 64'(0));

    // reset asserted mid-operation aborts and clears the result
    issue(8'h77, 8'h11, 1'b0, 1'b0, 8'h88, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    sb_q.delete();
    held_sum = '0;
    held_cout = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) rst_n = 1'b1;
      check("abort_no_done", 64'(done), 64'(0));
    end
    run_one("after_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, -1);

    // back-to-back: start held through DONE reloads with no IDLE gap
    issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0);
    begin
      exp_t e2;
      e2.sum = 8'h30;
      e2.cout = 1'b0;
      sb_q.push_back(e2);
    end
    @(posedge clk);
    #1;
    check("b2b_busy_e0", 64'(busy), 64'(1));
    wait_done("b2b_first", -1);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_no_gap_busy", 64'(busy), 64'(1));
    check("b2b_no_gap_done", 64'(done), 64'(0));
    wait_done("b2b_second", -1);
    @(posedge clk);
    #1;
    check("b2b_idle", 64'(done), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
    run_one("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, -1);
    run_one("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, -1);
    run_one("add_after_sub", 8'h00, 8'h01, 1'b1, 1'b0, 8'h02, 1'b0, -1);
`endif

    check("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
